// File: rtl/fifo_uart_tx_drain_if.sv
// rtl/fifo_uart_tx_drain_if.sv - FIFO read port and serial line bundle for fifo_uart_tx_drain
//
// Purpose: carries everything between the drain block and its neighbours
// except clk/reset.
// Ports (as seen by the master / drain side):
//   enable      in   allow new frames to start
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_cs     out  FIFO chip select, same timing as fifo_rd_en
//   fifo_rd_en  out  one-cycle pop strobe
//   tx          out  serial line, idles high
//   busy        out  high whenever a frame is in progress
//   frame_done  out  pulse on the last clk of each stop bit
//   frame_count out  completed frame counter, wraps
interface fifo_uart_tx_drain_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   enable;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   fifo_cs;
  logic                   fifo_rd_en;
  logic                   tx;
  logic                   busy;
  logic                   frame_done;
  logic [COUNT_WIDTH-1:0] frame_count;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_cs, fifo_rd_en, tx, busy, frame_done, frame_count
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_cs, fifo_rd_en, tx, busy, frame_done, frame_count
  );
endinterface

// File: rtl/fifo_uart_tx_drain.sv
// rtl/fifo_uart_tx_drain.sv - pops FIFO words and serialises them as start/data/stop frames
//
// Purpose: whenever enabled and the FIFO is non-empty, pop one word and send
// it LSB first between a 0 start bit and a 1 stop bit, CLKS_PER_BIT clocks
// per bit.
// Ports:
//   clk    in  rising-edge system clock
//   reset  in  asynchronous active-high reset
//   bus    master modport of fifo_uart_tx_drain_if (FIFO read port, serial
//          line and status)
module fifo_uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_uart_tx_drain_if.master  bus
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LATCH, S_START, S_DATA, S_STOP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [DIV_W-1:0]       r_div, w_div_nxt;
  logic [BIT_W-1:0]       r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic                   w_div_last;
  logic                   w_count_inc;
  logic                   w_tx_nxt;

  logic                   r_tx;
  logic                   r_rd_en;
  logic                   r_busy;
  logic                   r_frame_done;
  logic [COUNT_WIDTH-1:0] r_frame_count;

  assign w_div_last = (r_div == DIV_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_count_inc = 1'b0;
    case (r_state)
      // empty is only looked at here, so a pop can never hit an empty FIFO
      S_IDLE: if (bus.enable && !bus.fifo_empty) w_state_nxt = S_POP;
      S_POP:  w_state_nxt = S_LATCH;
      // fifo_data reflects the pop one cycle after the strobe
      S_LATCH: begin
        w_shift_nxt = bus.fifo_data;
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_count_inc = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they belong to rather than lagging it by a cycle.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_tx          <= 1'b1;
      r_rd_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_rd_en      <= (w_state_nxt == S_POP);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_STOP) && (w_div_nxt == DIV_LAST);
      if (w_count_inc) r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.fifo_cs     = r_rd_en;
  assign bus.fifo_rd_en  = r_rd_en;
  assign bus.tx          = r_tx;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// tb/tb_fifo_uart_tx_drain.sv - self-checking bench for fifo_uart_tx_drain
module tb_fifo_uart_tx_drain;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int CW  = 16;
  localparam int CW2 = 2;
  localparam int FW  = (DW + 2) * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_drain_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW))  ifc  ();
  fifo_uart_tx_drain_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW2)) ifc2 ();

  fifo_uart_tx_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(ifc.master));
  fifo_uart_tx_drain #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .COUNT_WIDTH(CW2)) dut2 (
    .clk(clk), .reset(reset), .bus(ifc2.master));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int exp_count  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous FIFO model: data_out updates on the pop edge
  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            pops   = 0;
  logic          underflow = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  assign ifc.fifo_empty = (wr_ptr == rd_ptr);
  assign ifc.fifo_data  = fifo_dout;
  always @(posedge clk) begin
    if (ifc.fifo_rd_en === 1'b1) begin
      if (wr_ptr == rd_ptr) underflow <= 1'b1;
      else begin
        fifo_dout <= mem[rd_ptr[5:0]];
        rd_ptr    <= rd_ptr + 1;
      end
      pops <= pops + 1;
    end
  end

  assign ifc2.fifo_empty = 1'b0;
  assign ifc2.fifo_data  = 8'h55;

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // expected line level for every clk of a frame, from the framing rule alone
  function automatic logic [FW-1:0] frame_wave(input logic [DW-1:0] d);
    logic [DW+1:0] bits;
    logic [FW-1:0] w;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < FW; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  task automatic run_frame(input logic [DW-1:0] b, input int drop_at,
                           output int start_cyc, output int end_cyc);
    int t;
    logic [FW-1:0] wave, fd, bz;
    t = 0;
    while (ifc.fifo_rd_en !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    chk("pop_seen", 64'(t < 400), 1);
    chk("cs_with_rd_en", ifc.fifo_cs, 1);
    t = 0;
    while (ifc.tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    chk("pop_to_start", t, 2);
    start_cyc = cyc;
    for (int i = 0; i < FW; i++) begin
      if (i == drop_at) ifc.enable = 1'b0;
      wave[i] = ifc.tx;
      fd[i]   = ifc.frame_done;
      bz[i]   = ifc.busy;
      if (i < FW - 1) @(negedge clk);
    end
    end_cyc = cyc;
    chk("tx_wave", wave, frame_wave(b));
    chk("frame_done_pos", fd, {1'b1, {(FW-1){1'b0}}});
    chk("busy_in_frame", bz, {FW{1'b1}});
    exp_count++;
    @(negedge clk);
    chk("frame_count", ifc.frame_count, exp_count & 32'hFFFF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s, e, ps, pe, p0, t;
    logic bad;
    logic [DW-1:0] rb [0:5];
    logic [DW-1:0] w0, w1;

    ifc.enable  = 1'b0;
    ifc2.enable = 1'b0;
    reset       = 1'b1;

    // reset with FIFO non-empty and enable high: nothing may move
    push(8'hA5);
    ifc.enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", ifc.tx, 1);
    chk("rst_rd_en", ifc.fifo_rd_en, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_frame_done", ifc.frame_done, 0);
    chk("rst_count", ifc.frame_count, 0);
    chk("rst_no_pop", pops, 0);
    reset = 1'b0;

    // single frame 0xA5
    run_frame(8'hA5, -1, s, e);
    chk("single_pops", pops, 1);

    // three back-to-back frames
    do_reset();
    p0 = pops;
    push(8'h00); push(8'hFF); push(8'h3C);
    run_frame(8'h00, -1, ps, pe);
    run_frame(8'hFF, -1, s, e);
    chk("gap_1_2", s - pe - 1, 3);
    pe = e;
    run_frame(8'h3C, -1, s, e);
    chk("gap_2_3", s - pe - 1, 3);
    repeat (20) @(negedge clk);
    chk("three_pops", pops - p0, 3);
    chk("no_underflow", underflow, 0);
    chk("three_count", ifc.frame_count, 3);
    chk("idle_busy", ifc.busy, 0);

    // random words back to back
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      rb[i] = DW'($urandom);
      push(rb[i]);
    end
    pe = -1;
    for (int i = 0; i < 6; i++) begin
      run_frame(rb[i], -1, s, e);
      if (i > 0) chk("rand_gap", s - pe - 1, 3);
      pe = e;
    end
    repeat (10) @(negedge clk);
    chk("rand_pops", pops - p0, 6);
    chk("rand_no_underflow", underflow, 0);

    // disabled with two words queued, then enable dropped mid-frame
    ifc.enable = 1'b0;
    w0 = DW'($urandom);
    w1 = DW'($urandom);
    push(w0); push(w1);
    p0  = pops;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.fifo_rd_en !== 1'b0 || ifc.tx !== 1'b1) bad = 1'b1;
    end
    chk("disabled_quiet", bad, 0);
    ifc.enable = 1'b1;
    run_frame(w0, CPB * 4 + 1, s, e);
    repeat (50) @(negedge clk);
    chk("drop_one_pop", pops - p0, 1);
    chk("drop_busy", ifc.busy, 0);
    chk("drop_tx", ifc.tx, 1);
    ifc.enable = 1'b1;
    run_frame(w1, -1, s, e);

    // reset during data bit 4 of 0x5A; 0x81 follows
    p0 = pops;
    push(8'h5A); push(8'h81);
    t = 0;
    while (ifc.fifo_rd_en !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ifc.tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    chk("abort_start_seen", 64'(t < 20), 1);
    repeat (CPB * 5 + 1) @(negedge clk);
    chk("abort_busy_before", ifc.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_tx", ifc.tx, 1);
    chk("abort_busy", ifc.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    run_frame(8'h81, -1, s, e);
    chk("abort_pops", pops - p0, 2);

    // narrow counter wraps
    ifc.enable  = 1'b0;
    ifc2.enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (ifc2.frame_done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      chk("wrap_done_seen", 64'(t < 200), 1);
      @(negedge clk);
      chk("wrap_count", ifc2.frame_count, (k + 1) % 4);
    end
    ifc2.enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
